cmd_responder: RTL and testbench

Far end of the command link. Receives a 16-bit command over a UART serial line as two bytes, high byte first, and presents the assembled command to local logic with a ready/clear handshake. On request, it transmits a single 8-bit response byte back over the same link. It contains its own UART RX/TX engine and byte-framing logic. It sits at the device boundary, between the serial pins and the command-processing FSM.

---
 rtl/comm_pkg.sv | 16 +
 rtl/uart_sync_xcvr.sv | 149 ++++++++++++++
 rtl/cmd_responder.sv | 89 ++++++++
 tb/tb_cmd_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared state types and default timing constants for the command-link
// UART and its byte-framing logic.
package comm_pkg;

    typedef enum logic {WAIT_HIGH, WAIT_LOW} frame_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {TX_IDLE, START, DATA, STOP} tx_state_t;

    localparam int DEF_BAUD_DIV    = 2604;
    localparam int DEF_TIMEOUT_CYC = 65536;

endpackage

// File: rtl/uart_sync_xcvr.sv
// Full-duplex 8N1 UART engine: independent RX and TX state machines.
// rx: RX_IDLE wait edge | RX_START recheck mid-start | RX_DATA 8 bits | RX_STOP check stop | RX_WAIT_IDLE wait line high
// tx: TX_IDLE wait trmt | START start bit | DATA 8 bits | STOP stop bit
module uart_sync_xcvr
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       stop_err,
    output logic       rx_idle,
    input  logic       trmt,
    input  logic [7:0] tx_byte,
    output logic       tx_done,
    output logic       tx_busy
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    logic          rx_s1, rx_s2, rx_s3;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_sh;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_sh;

    assign rx_idle = (rx_state == RX_IDLE);

    // rx_s3 only serves falling-edge detection on the synchronized line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            byte_rdy <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            byte_rdy <= 1'b0;
            stop_err <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_s3 && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= HALF_LAST;
                end
                RX_START: if (rx_cnt != '0) begin
                    rx_cnt <= rx_cnt - 1'b1;
                end else if (rx_s2) begin
                    rx_state <= RX_IDLE;
                end else begin
                    rx_state <= RX_DATA;
                    rx_cnt   <= BIT_LAST;
                    rx_idx   <= '0;
                end
                RX_DATA: if (rx_cnt != '0) begin
                    rx_cnt <= rx_cnt - 1'b1;
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_cnt <= BIT_LAST;
                    rx_idx <= rx_idx + 1'b1;
                    if (rx_idx == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_cnt != '0) begin
                    rx_cnt <= rx_cnt - 1'b1;
                end else if (rx_s2) begin
                    rx_byte  <= rx_sh;
                    byte_rdy <= 1'b1;
                    rx_state <= RX_IDLE;
                end else begin
                    stop_err <= 1'b1;
                    rx_state <= RX_WAIT_IDLE;
                end
                RX_WAIT_IDLE: if (rx_s2) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: if (trmt) begin
                    tx_sh    <= tx_byte;
                    tx       <= 1'b0;
                    tx_busy  <= 1'b1;
                    tx_cnt   <= BIT_LAST;
                    tx_state <= START;
                end
                START: if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - 1'b1;
                end else begin
                    tx       <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_cnt   <= BIT_LAST;
                    tx_idx   <= '0;
                    tx_state <= DATA;
                end
                DATA: if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - 1'b1;
                end else begin
                    tx_cnt <= BIT_LAST;
                    if (tx_idx == 3'd7) begin
                        tx       <= 1'b1;
                        tx_state <= STOP;
                    end else begin
                        tx     <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_idx <= tx_idx + 1'b1;
                    end
                end
                STOP: if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - 1'b1;
                end else begin
                    tx_done  <= 1'b1;
                    tx_busy  <= 1'b0;
                    tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_responder.sv
// Command-link far end: assembles two received bytes into a 16-bit command
// and sends single-byte responses. state | meaning: WAIT_HIGH expect high byte | WAIT_LOW expect low byte
module cmd_responder
    import comm_pkg::*;
#(
    parameter int BAUD_DIV    = DEF_BAUD_DIV,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frame_err,
    output logic        overrun
);
    localparam int GW = $clog2(TIMEOUT_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

    logic         byte_rdy, stop_err, rx_idle;
    logic [7:0]   rx_byte;
    logic [7:0]   hi_byte;
    logic [GW-1:0] gap_cnt;
    frame_state_t state;

    // the engine itself ignores trmt while a response is in flight
    uart_sync_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .tx       (TX),
        .byte_rdy (byte_rdy),
        .rx_byte  (rx_byte),
        .stop_err (stop_err),
        .rx_idle  (rx_idle),
        .trmt     (send_resp),
        .tx_byte  (resp),
        .tx_done  (resp_sent),
        .tx_busy  (tx_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_HIGH;
            hi_byte   <= '0;
            gap_cnt   <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= 1'b0;
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            case (state)
                WAIT_HIGH: if (byte_rdy) begin
                    hi_byte <= rx_byte;
                    gap_cnt <= '0;
                    state   <= WAIT_LOW;
                end
                WAIT_LOW: if (byte_rdy) begin
                    // completion overrides a same-cycle clear
                    cmd     <= {hi_byte, rx_byte};
                    cmd_rdy <= 1'b1;
                    overrun <= cmd_rdy;
                    state   <= WAIT_HIGH;
                end else if (stop_err) begin
                    state <= WAIT_HIGH;
                end else if (rx_idle) begin
                    if (gap_cnt == GAP_LAST) begin
                        hi_byte   <= '0;
                        frame_err <= 1'b1;
                        state     <= WAIT_HIGH;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder with a scoreboard of expected commands
// and transmitted bits.
module tb_cmd_responder;
    localparam int BD = 16;
    localparam int TO = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_line;
    logic        tx_line;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int evt_cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int rs_cnt = 0;
    int low_start = 0;
    int ferr0, ovr0;
    logic rdy_q = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic        bit_q[$];

    cmd_responder #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (rx_line),
        .TX          (tx_line),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_busy     (tx_busy),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // frame completions are a rising cmd_rdy or an overrun pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if ((cmd_rdy && !rdy_q) || overrun) begin
                obs_q.push_back(cmd);
                evt_cyc = cyc;
            end
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
            if (resp_sent) rs_cnt++;
        end
        rdy_q = cmd_rdy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int clr_at);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10 * BD; i++) begin
            rx_line     = fr[4'(i / BD)];
            clr_cmd_rdy = (i == clr_at);
            tick(1);
        end
        rx_line     = 1'b1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input int clr_at);
        exp_q.push_back({hi, lo});
        send_byte(hi, 1'b1, -1);
        low_start = cyc;
        send_byte(lo, 1'b1, clr_at);
    endtask

    task automatic check_frame(input string tag);
        logic [15:0] e;
        logic [15:0] o;
        e = exp_q.pop_front();
        chk({tag, "_count"}, obs_q.size(), 1);
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
        chk({tag, "_cmd"}, o, e);
        obs_q.delete();
    endtask

    task automatic clear_rdy();
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_line = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
        tick(3);
        chk("rst_tx", tx_line, 1);
        chk("rst_cmd", cmd, 0);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_resp_sent", resp_sent, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(5);

        // 1: basic frame and clear
        send_frame(8'h12, 8'h34, -1);
        tick(2);
        check_frame("t1");
        chk("t1_latency", evt_cyc - low_start, 156);
        chk("t1_rdy", cmd_rdy, 1);
        clear_rdy();
        chk("t1_clr_rdy", cmd_rdy, 0);
        chk("t1_clr_cmd", cmd, 16'h1234);

        // 2: response byte, second request ignored
        rs_cnt = 0;
        bit_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        resp = 8'hA5; send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0; resp = 8'hFF;
        for (int t = 0; t < 170; t++) begin
            if (t % BD == 8 && t < 10 * BD) begin
                chk("t2_tx_bit", tx_line, bit_q.pop_front());
                chk("t2_busy_mid", tx_busy, 1);
            end
            if (t == 39) send_resp = 1'b1;
            if (t == 40) send_resp = 1'b0;
            if (t == 159) begin
                chk("t2_busy_last", tx_busy, 1);
                chk("t2_sent_early", resp_sent, 0);
            end
            if (t == 160) begin
                chk("t2_busy_drop", tx_busy, 0);
                chk("t2_sent_pulse", resp_sent, 1);
            end
            tick(1);
        end
        chk("t2_sent_count", rs_cnt, 1);
        chk("t2_tx_idle", tx_line, 1);

        // 3: inter-byte timeout
        ferr0 = ferr_cnt;
        send_byte(8'hAB, 1'b1, -1);
        tick(600);
        chk("t3_timeout_err", ferr_cnt, ferr0 + 1);
        chk("t3_rdy_low", cmd_rdy, 0);
        chk("t3_no_frame", obs_q.size(), 0);
        send_frame(8'h56, 8'h78, -1);
        tick(2);
        check_frame("t3");
        clear_rdy();

        // 4: bad stop bit on the high byte
        ferr0 = ferr_cnt;
        send_byte(8'h12, 1'b0, -1);
        tick(20);
        chk("t4_stop_err", ferr_cnt, ferr0 + 1);
        chk("t4_no_frame", obs_q.size(), 0);
        send_frame(8'h9A, 8'hBC, -1);
        tick(2);
        check_frame("t4");
        chk("t4_no_more_err", ferr_cnt, ferr0 + 1);
        clear_rdy();

        // 5: overrun, clear coinciding with completion
        ovr0 = ovr_cnt;
        send_frame(8'h01, 8'h02, -1);
        tick(2);
        check_frame("t5a");
        chk("t5_no_ovr", ovr_cnt, ovr0);
        send_frame(8'h03, 8'h04, 155);
        tick(2);
        check_frame("t5b");
        chk("t5_ovr", ovr_cnt, ovr0 + 1);
        chk("t5_rdy_kept", cmd_rdy, 1);
        chk("t5_cmd", cmd, 16'h0304);

        // 6: reset mid-transfer in both directions
        ferr0 = ferr_cnt;
        resp = 8'h3C; send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 60; i++) begin
                rx_line = fr[4'(i / BD)];
                tick(1);
            end
        end
        rst_n = 1'b0;
        tick(1);
        chk("t6_tx", tx_line, 1);
        chk("t6_busy", tx_busy, 0);
        chk("t6_rdy", cmd_rdy, 0);
        chk("t6_cmd", cmd, 0);
        chk("t6_ferr", frame_err, 0);
        rx_line = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(200);
        chk("t6_no_err", ferr_cnt, ferr0);
        obs_q.delete();
        send_frame(8'hCA, 8'hFE, -1);
        tick(2);
        check_frame("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
